// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare/BTB branch predictor.
package bp_pkg;

   // Widest address and counter the shared types can hold; instances use the low bits.
   localparam int unsigned BP_ADDR_MAX = 64;
   localparam int unsigned BP_CTR_MAX  = 8;

   // Kind of control instruction cached in a BTB entry.
   typedef enum logic {
      BR   = 1'b0,
      JUMP = 1'b1
   } btb_type_e;

   // Counter reset value: weakly not-taken. Callers cast it to their CTR_W.
   localparam logic [BP_CTR_MAX-1:0] CTR_INIT = BP_CTR_MAX'(1);

   // One BTB entry. Tag and target are zero-extended into the wide fields.
   typedef struct packed {
      logic                   valid;
      btb_type_e              kind;
      logic [BP_ADDR_MAX-1:0] tag;
      logic [BP_ADDR_MAX-1:0] target;
   } btb_entry_t;

   // Saturating increment of a w-bit counter held in the low bits of v.
   function automatic logic [BP_CTR_MAX-1:0] sat_inc(input logic [BP_CTR_MAX-1:0] v,
                                                     input int unsigned w);
      logic [BP_CTR_MAX-1:0] top;
      top = BP_CTR_MAX'((1 << w) - 1);
      return (v >= top) ? top : v + BP_CTR_MAX'(1);
   endfunction

   // Saturating decrement; stops at zero.
   function automatic logic [BP_CTR_MAX-1:0] sat_dec(input logic [BP_CTR_MAX-1:0] v);
      return (v == '0) ? '0 : v - BP_CTR_MAX'(1);
   endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: saturating counters, one combinational read port
// and one synchronous read-modify-write update port.
module gshare_pht
   import bp_pkg::*;
#(
   parameter int PHT_IDX_W = 6,
   parameter int CTR_W     = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PHT_IDX_W-1:0] rd_idx_i,
   output logic [CTR_W-1:0]     rd_ctr_o,
   input  logic                 upd_en_i,
   input  logic [PHT_IDX_W-1:0] upd_idx_i,
   input  logic                 upd_taken_i
);

   localparam int PHT_N = 2 ** PHT_IDX_W;

   logic [CTR_W-1:0] ctr_q [PHT_N];
   logic [CTR_W-1:0] ctr_d;

   // Lookup sees the table as it stood before this cycle's update.
   assign rd_ctr_o = ctr_q[rd_idx_i];

   // New value for the counter being trained.
   always_comb begin
      ctr_d = ctr_q[upd_idx_i];
      if (upd_taken_i) begin
         ctr_d = CTR_W'(sat_inc(BP_CTR_MAX'(ctr_q[upd_idx_i]), CTR_W));
      end else begin
         ctr_d = CTR_W'(sat_dec(BP_CTR_MAX'(ctr_q[upd_idx_i])));
      end
   end

   // Whole table returns to weakly not-taken on reset; otherwise commit the trained counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PHT_N; i++) begin
            ctr_q[i] <= CTR_W'(CTR_INIT);
         end
      end else if (upd_en_i) begin
         ctr_q[upd_idx_i] <= ctr_d;
      end
   end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Fetch-stage predictor: tagged direct-mapped BTB, gshare PHT and a
// speculative global history register restored from EX snapshots.
module gshare_btb_predictor
   import bp_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BTB_IDX_W = 5,
   parameter int PHT_IDX_W = 6,
   parameter int HIST_LEN  = 5,
   parameter int CTR_W     = 2,
   parameter int PERF_W    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [XLEN-1:0]     pred_pc,
   input  logic                pred_valid,
   output logic [XLEN-1:0]     pred_next_pc,
   output logic                pred_taken,
   output logic [HIST_LEN-1:0] pred_hist,
   input  logic                upd_valid,
   input  logic [XLEN-1:0]     upd_pc,
   input  logic                upd_is_branch,
   input  logic                upd_is_jump,
   input  logic                upd_taken,
   input  logic [XLEN-1:0]     upd_target,
   input  logic [HIST_LEN-1:0] upd_hist,
   input  logic                upd_mispredict,
   output logic [PERF_W-1:0]   perf_lookups,
   output logic [PERF_W-1:0]   perf_mispredicts
);

   localparam int BTB_N = 2 ** BTB_IDX_W;
   localparam int TAG_W = XLEN - 2 - BTB_IDX_W;

   btb_entry_t          btb_q [BTB_N];
   logic [HIST_LEN-1:0] ghr_q, ghr_d;
   logic [PERF_W-1:0]   perf_lookups_q, perf_mispredicts_q;

   // ---- lookup path ----
   logic [BTB_IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0]     lk_tag;
   btb_entry_t           lk_entry;
   logic                 lk_hit;
   logic [PHT_IDX_W-1:0] lk_pht_idx;
   logic [CTR_W-1:0]     lk_ctr;

   assign lk_idx     = pred_pc[2 +: BTB_IDX_W];
   assign lk_tag     = pred_pc[XLEN-1 -: TAG_W];
   assign lk_entry   = btb_q[lk_idx];
   assign lk_hit     = lk_entry.valid && (lk_entry.tag == BP_ADDR_MAX'(lk_tag));
   assign lk_pht_idx = pred_pc[2 +: PHT_IDX_W] ^ PHT_IDX_W'(ghr_q);

   assign pred_taken   = lk_hit && ((lk_entry.kind == JUMP) || lk_ctr[CTR_W-1]);
   assign pred_next_pc = pred_taken ? XLEN'(lk_entry.target) : pred_pc + XLEN'(4);
   assign pred_hist    = ghr_q;

   // ---- update path ----
   logic [BTB_IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0]     upd_tag;
   logic [PHT_IDX_W-1:0] upd_pht_idx;
   logic                 btb_wr;
   btb_entry_t           upd_entry;
   logic                 unused_upd_pc_lsb;

   assign upd_idx           = upd_pc[2 +: BTB_IDX_W];
   assign upd_tag           = upd_pc[XLEN-1 -: TAG_W];
   assign upd_pht_idx       = upd_pc[2 +: PHT_IDX_W] ^ PHT_IDX_W'(upd_hist);
   assign btb_wr            = upd_valid && (upd_is_jump || (upd_is_branch && upd_taken));
   assign unused_upd_pc_lsb = ^upd_pc[1:0];

   assign upd_entry.valid  = 1'b1;
   assign upd_entry.kind   = upd_is_jump ? JUMP : BR;
   assign upd_entry.tag    = BP_ADDR_MAX'(upd_tag);
   assign upd_entry.target = BP_ADDR_MAX'(upd_target);

   gshare_pht #(
      .PHT_IDX_W (PHT_IDX_W),
      .CTR_W     (CTR_W)
   ) u_pht (
      .clk         (clk),
      .reset       (reset),
      .rd_idx_i    (lk_pht_idx),
      .rd_ctr_o    (lk_ctr),
      .upd_en_i    (upd_valid && upd_is_branch),
      .upd_idx_i   (upd_pht_idx),
      .upd_taken_i (upd_taken)
   );

   // ---- history ----
   logic [HIST_LEN-1:0] ghr_spec, ghr_recov;

   if (HIST_LEN == 1) begin : g_hist1
      assign ghr_spec  = pred_taken;
      assign ghr_recov = upd_is_branch ? upd_taken : upd_hist;
   end else begin : g_histn
      assign ghr_spec  = {ghr_q[HIST_LEN-2:0], pred_taken};
      assign ghr_recov = upd_is_branch ? {upd_hist[HIST_LEN-2:0], upd_taken} : upd_hist;
   end

   // Recovery from EX wins over the speculative shift; only BTB-hit branches shift.
   always_comb begin
      ghr_d = ghr_q;
      if (upd_valid && upd_mispredict) begin
         ghr_d = ghr_recov;
      end else if (pred_valid && lk_hit && (lk_entry.kind == BR)) begin
         ghr_d = ghr_spec;
      end
   end

   // BTB, GHR and saturating perf counters; reset drops any in-flight update.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BTB_N; i++) begin
            btb_q[i] <= '0;
         end
         ghr_q              <= '0;
         perf_lookups_q     <= '0;
         perf_mispredicts_q <= '0;
      end else begin
         if (btb_wr) begin
            btb_q[upd_idx] <= upd_entry;
         end
         ghr_q <= ghr_d;
         if (pred_valid && (perf_lookups_q != '1)) begin
            perf_lookups_q <= perf_lookups_q + PERF_W'(1);
         end
         if (upd_valid && upd_mispredict && (perf_mispredicts_q != '1)) begin
            perf_mispredicts_q <= perf_mispredicts_q + PERF_W'(1);
         end
      end
   end

   assign perf_lookups     = perf_lookups_q;
   assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Bench for gshare_btb_predictor: directed vector table, hand-written
// corner sequences, then randomized traffic against an arithmetic model.
module tb_gshare_btb_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pred_pc;
   logic        pred_valid;
   logic [31:0] pred_next_pc;
   logic        pred_taken;
   logic [4:0]  pred_hist;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_is_branch;
   logic        upd_is_jump;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic [4:0]  upd_hist;
   logic        upd_mispredict;
   logic [31:0] perf_lookups;
   logic [31:0] perf_mispredicts;

   int n_tests = 0;
   int n_fail  = 0;

   gshare_btb_predictor dut (
      .clk              (clk),
      .reset            (reset),
      .pred_pc          (pred_pc),
      .pred_valid       (pred_valid),
      .pred_next_pc     (pred_next_pc),
      .pred_taken       (pred_taken),
      .pred_hist        (pred_hist),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_is_branch    (upd_is_branch),
      .upd_is_jump      (upd_is_jump),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_hist         (upd_hist),
      .upd_mispredict   (upd_mispredict),
      .perf_lookups     (perf_lookups),
      .perf_mispredicts (perf_mispredicts)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // 32-entry BTB, 64-entry PHT of 0..3 counters, 5-bit history as an integer.
   bit          m_valid [32];
   int unsigned m_tag   [32];
   int unsigned m_tgt   [32];
   bit          m_jmp   [32];
   int          m_pht   [64];
   int unsigned m_ghr;
   longint      m_lk;
   longint      m_mp;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_jmp[i] = 0;
      end
      for (int i = 0; i < 64; i++) m_pht[i] = 1;
      m_ghr = 0; m_lk = 0; m_mp = 0;
   endfunction

   function automatic void model_lookup(input int unsigned pc, output bit hit,
                                        output bit tk, output int unsigned nxt);
      int unsigned bi, pi;
      bi  = (pc / 4) % 32;
      pi  = ((pc / 4) % 64) ^ m_ghr;
      hit = m_valid[bi] && (m_tag[bi] == pc / 128);
      tk  = hit && (m_jmp[bi] || m_pht[pi] >= 2);
      nxt = tk ? m_tgt[bi] : pc + 4;
   endfunction

   function automatic void model_update();
      bit hit, tk;
      int unsigned nxt, bi, pi;
      model_lookup(pred_pc, hit, tk, nxt);
      bi = (pred_pc / 4) % 32;
      if (upd_valid && upd_is_branch) begin
         pi = ((upd_pc / 4) % 64) ^ upd_hist;
         if (upd_taken) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
         else           m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
      end
      if (upd_valid && upd_mispredict)
         m_ghr = upd_is_branch ? (m_ghr * 0 + (upd_hist * 2 + upd_taken) % 32) : upd_hist;
      else if (pred_valid && hit && !m_jmp[bi])
         m_ghr = (m_ghr * 2 + tk) % 32;
      if (upd_valid && (upd_is_jump || (upd_is_branch && upd_taken))) begin
         m_valid[(upd_pc / 4) % 32] = 1;
         m_tag  [(upd_pc / 4) % 32] = upd_pc / 128;
         m_tgt  [(upd_pc / 4) % 32] = upd_target;
         m_jmp  [(upd_pc / 4) % 32] = upd_is_jump;
      end
      if (pred_valid && m_lk < 64'hFFFF_FFFF) m_lk++;
      if (upd_valid && upd_mispredict && m_mp < 64'hFFFF_FFFF) m_mp++;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic pv, input logic uv,
                        input logic [31:0] upc, input logic ub, input logic uj,
                        input logic ut, input logic [31:0] utgt, input logic [4:0] uh,
                        input logic um);
      pred_pc = pc; pred_valid = pv; upd_valid = uv; upd_pc = upc;
      upd_is_branch = ub; upd_is_jump = uj; upd_taken = ut; upd_target = utgt;
      upd_hist = uh; upd_mispredict = um;
   endtask

   task automatic idle();
      drive(32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 5'd0, 0);
   endtask

   // Check outputs against the model, clock once, advance the model.
   task automatic cycle();
      bit hit, tk;
      int unsigned nxt;
      #1;
      model_lookup(pred_pc, hit, tk, nxt);
      chk("pred_taken",       pred_taken,       tk);
      chk("pred_next_pc",     pred_next_pc,     nxt);
      chk("pred_hist",        pred_hist,        m_ghr);
      chk("perf_lookups",     perf_lookups,     m_lk);
      chk("perf_mispredicts", perf_mispredicts, m_mp);
      @(posedge clk);
      if (reset) model_reset();
      else       model_update();
      @(negedge clk);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [31:0] pc;  logic pv;
      logic        uv;  logic [31:0] upc; logic ub; logic uj; logic ut;
      logic [31:0] utgt; logic [4:0] uh; logic um;
      logic        et;  logic [31:0] en;  logic [4:0] eh;
   } vec_t;

   vec_t vecs [6];

   initial begin
      // lookup after reset; jal install; jal hit; gshare branch taken then not taken
      vecs[0] = '{32'h40, 1, 0, 32'h00, 0, 0, 0, 32'h000, 5'd0, 0, 0, 32'h44,  5'd0};
      vecs[1] = '{32'h40, 0, 1, 32'h10, 0, 1, 1, 32'h080, 5'd0, 0, 0, 32'h44,  5'd0};
      vecs[2] = '{32'h10, 1, 1, 32'h20, 1, 0, 1, 32'h100, 5'd0, 0, 1, 32'h80,  5'd0};
      vecs[3] = '{32'h20, 1, 0, 32'h00, 0, 0, 0, 32'h000, 5'd0, 0, 1, 32'h100, 5'd0};
      vecs[4] = '{32'h20, 1, 0, 32'h00, 0, 0, 0, 32'h000, 5'd0, 0, 0, 32'h24,  5'd1};
      vecs[5] = '{32'h40, 1, 0, 32'h00, 0, 0, 0, 32'h000, 5'd0, 0, 0, 32'h44,  5'd2};

      reset = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      chk("reset_perf_lookups", perf_lookups, 64'd0);
      chk("reset_perf_mispredicts", perf_mispredicts, 64'd0);

      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].pc, vecs[i].pv, vecs[i].uv, vecs[i].upc, vecs[i].ub, vecs[i].uj,
               vecs[i].ut, vecs[i].utgt, vecs[i].uh, vecs[i].um);
         #1;
         chk($sformatf("vec%0d_taken", i), pred_taken,   vecs[i].et);
         chk($sformatf("vec%0d_next",  i), pred_next_pc, vecs[i].en);
         chk($sformatf("vec%0d_hist",  i), pred_hist,    vecs[i].eh);
         cycle();
      end

      // Recovery priority: force GHR=10110 via jump recovery, then a branch
      // recovery in the same cycle as a BTB-hit branch lookup.
      drive(32'h40, 0, 1, 32'h300, 0, 1, 1, 32'h400, 5'b10110, 1);
      cycle();
      drive(32'h20, 1, 1, 32'h200, 1, 0, 0, 32'h0, 5'b00011, 1);
      #1;
      chk("recov_hist_before", pred_hist, 64'b10110);
      cycle();
      idle();
      #1;
      chk("recov_hist_after", pred_hist, 64'b00110);
      chk("recov_perf_mp", perf_mispredicts, 64'd2);
      cycle();

      // Saturation at the low bound, then at the high bound.
      for (int i = 0; i < 5; i++) begin
         drive(32'h0, 0, 1, 32'h20, 1, 0, 0, 32'h0, 5'd0, 0);
         cycle();
      end
      drive(32'h0, 0, 1, 32'h300, 0, 1, 1, 32'h400, 5'd0, 1);
      cycle();
      drive(32'h20, 1, 0, 32'h0, 0, 0, 0, 32'h0, 5'd0, 0);
      #1;
      chk("sat_low_taken", pred_taken, 64'd0);
      chk("sat_low_next", pred_next_pc, 64'h24);
      cycle();
      for (int i = 0; i < 4; i++) begin
         drive(32'h0, 0, 1, 32'h20, 1, 0, 1, 32'h100, 5'd0, 0);
         cycle();
      end
      drive(32'h20, 1, 0, 32'h0, 0, 0, 0, 32'h0, 5'd0, 0);
      #1;
      chk("sat_high_taken", pred_taken, 64'd1);
      chk("sat_high_next", pred_next_pc, 64'h100);
      cycle();

      // Aliasing: jal at 0xA0 evicts the 0x20 entry; then reset clears everything.
      drive(32'h0, 0, 1, 32'hA0, 0, 1, 1, 32'h500, 5'd0, 0);
      cycle();
      drive(32'h20, 1, 0, 32'h0, 0, 0, 0, 32'h0, 5'd0, 0);
      #1;
      chk("alias_taken", pred_taken, 64'd0);
      chk("alias_next", pred_next_pc, 64'h24);
      cycle();
      reset = 1'b1;
      drive(32'hA0, 1, 1, 32'h60, 0, 1, 1, 32'h700, 5'd3, 1);
      cycle();
      reset = 1'b0;
      drive(32'hA0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 5'd0, 0);
      #1;
      chk("post_reset_taken", pred_taken, 64'd0);
      chk("post_reset_next", pred_next_pc, 64'hA4);
      chk("post_reset_hist", pred_hist, 64'd0);
      chk("post_reset_perf_lk", perf_lookups, 64'd0);
      chk("post_reset_perf_mp", perf_mispredicts, 64'd0);
      cycle();
      // The update presented during reset must not have installed 0x60.
      drive(32'h60, 1, 0, 32'h0, 0, 0, 0, 32'h0, 5'd0, 0);
      #1;
      chk("reset_drops_update", pred_taken, 64'd0);
      cycle();

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         int kind;
         logic br_t;
         kind = $urandom_range(0, 2);
         br_t = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 299) == 0);
         drive(($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2),
               1'($urandom_range(0, 3) != 0),
               kind != 0,
               ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2),
               kind == 1, kind == 2,
               (kind == 2) ? 1'b1 : br_t,
               $urandom_range(0, 255) << 2,
               5'($urandom_range(0, 31)),
               1'($urandom_range(0, 3) == 0));
         cycle();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
